// File: rtl/button_pkg.sv
// Shared types and timing defaults for the push-button conditioner.
package button_pkg;

  // Per-channel press state; REPEATING is only reached in the auto-repeat build.
  typedef enum logic [1:0] {
    RELEASED  = 2'd0,
    PRESSED   = 2'd1,
    REPEATING = 2'd2
  } btn_state_e;

  localparam int unsigned CLK_HZ      = 100000000;
  localparam int unsigned DEBOUNCE_MS = 10;

  // Converts a duration in milliseconds to clk cycles.
  function automatic int unsigned ms_to_cycles(input int unsigned ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchronizer, debounce counter, press/release FSM and strobes.
// Optional auto-repeat of the press strobe under BUTTON_AUTOREPEAT_EN.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  btn_state_e             r_state;
  btn_state_e             w_state_nxt;
  logic                   r_press;
  logic                   r_release;
  logic                   w_press_nxt;
  logic                   w_release_nxt;
  logic                   w_sync;
  logic                   w_accept;
  logic                   w_rise;
  logic                   w_fall;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_accept = (w_sync != r_level) && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign w_rise   = w_accept && w_sync;
  assign w_fall   = w_accept && !w_sync;

  // Metastability synchronizer chain for the asynchronous pad input.
  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn_raw};
  end

  // Debounce: accept a change only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else if (w_sync == r_level) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_level <= w_sync;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;

  // State, hold counter and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_hold    <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_hold    <= w_hold_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next state and strobes; the hold counter measures time since the last press strobe.
  always_comb begin
    w_state_nxt   = r_state;
    w_hold_nxt    = r_hold;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
          w_hold_nxt    = '0;
        end else if (r_hold == HOLD_W'(REPEAT_DELAY - 1)) begin
          w_state_nxt = REPEATING;
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      REPEATING: begin
        if (w_fall) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
          w_hold_nxt    = '0;
        end else if (r_hold == HOLD_W'(REPEAT_PERIOD - 1)) begin
          w_press_nxt = 1'b1;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = RELEASED;
        w_hold_nxt  = '0;
      end
    endcase
  end
`else
  // State and strobe registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= RELEASED;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  // Next state and strobes: one press strobe per accepted press, one release per release.
  always_comb begin
    w_state_nxt   = r_state;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      RELEASED: begin
        if (w_rise) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (w_fall) begin
          w_state_nxt   = RELEASED;
          w_release_nxt = 1'b1;
        end
      end
      default: w_state_nxt = RELEASED;
    endcase
  end
`endif

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: N_BTN independent synchronize/debounce/strobe channels.
// Define BUTTON_AUTOREPEAT_EN to enable press auto-repeat while a button is held.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BTN           = 5,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = ms_to_cycles(DEBOUNCE_MS),
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  // One identical channel per button.
  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .i_btn_raw(btn_raw[g]),
      .o_level  (btn_level[g]),
      .o_press  (btn_press[g]),
      .o_release(btn_release[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized
// bouncing inputs compared against a sample-window reference model.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int HL   = SYNC + DEB;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level;
  logic [N-1:0] btn_press;
  logic [N-1:0] btn_release;

  int checks   = 0;
  int failures = 0;

  // Model: raw samples per edge (index 0 newest), accepted level, press times.
  logic [N-1:0] hist [HL];
  logic [N-1:0] m_level;
  logic [N-1:0] m_press;
  logic [N-1:0] m_release;
  int           press_edge [N];
  int           cyc = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .N_BTN          (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // A change is accepted once DEB consecutive synchronized samples all differ from the level.
  task automatic model_edge(input logic r, input logic [N-1:0] raw);
    cyc++;
    m_press   = '0;
    m_release = '0;
    if (r) begin
      for (int k = 0; k < HL; k++) hist[k] = '0;
      m_level = '0;
      return;
    end
    for (int k = HL - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = raw;
    for (int c = 0; c < N; c++) begin
      logic v;
      logic same;
      v    = hist[SYNC][c];
      same = 1'b1;
      for (int k = SYNC; k < HL; k++) if (hist[k][c] != v) same = 1'b0;
      if (same && v != m_level[c]) begin
        m_level[c] = v;
        if (v) begin
          m_press[c]    = 1'b1;
          press_edge[c] = cyc;
        end else begin
          m_release[c] = 1'b1;
        end
      end
`ifdef BUTTON_AUTOREPEAT_EN
      else if (m_level[c]) begin
        int t;
        t = cyc - press_edge[c];
        if (t >= RD && ((t - RD) % RP) == 0) m_press[c] = 1'b1;
      end
`endif
    end
  endtask

  // Apply inputs, clock once, advance the model and compare all outputs.
  task automatic step(input logic r, input logic [N-1:0] raw);
    rst     = r;
    btn_raw = raw;
    @(posedge clk);
    model_edge(r, raw);
    #1;
    check("level",   32'(btn_level),   32'(m_level));
    check("press",   32'(btn_press),   32'(m_press));
    check("release", 32'(btn_release), 32'(m_release));
    check("excl",    32'(btn_press & btn_release), 32'd0);
  endtask

  initial begin
    logic [N-1:0] tgt;
    int           tmr [N];
    logic [N-1:0] raw;
    int           np;
    for (int k = 0; k < HL; k++) hist[k] = '0;
    m_level = '0;
    for (int c = 0; c < N; c++) press_edge[c] = 0;

    // Reset state.
    for (int i = 0; i < 3; i++) step(1'b1, '0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_press", 32'(btn_press), 32'd0);

    // Clean press on button 0, held: strobe after edge 5 (plus repeats when enabled).
    np = 0;
    for (int e = 0; e <= 24; e++) begin
      logic exp_p;
      step(1'b0, 5'b00001);
      exp_p = (e == 5);
`ifdef BUTTON_AUTOREPEAT_EN
      if (e >= 15 && ((e - 15) % 3) == 0) exp_p = 1'b1;
`endif
      check("s1_press", 32'(btn_press[0]), 32'(exp_p));
      if (e >= 5) check("s1_level", 32'(btn_level[0]), 32'd1);
      if (btn_press[0]) np++;
    end
`ifdef BUTTON_AUTOREPEAT_EN
    check("s1_npress", 32'(np), 32'd5);
`else
    check("s1_npress", 32'(np), 32'd1);
`endif

    // Release: one strobe after edge k+5.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 5'b00000);
      check("s3_release", 32'(btn_release[0]), 32'(k == 5));
      check("s3_level",   32'(btn_level[0]),   32'(k < 5));
    end

    // Bounce rejection on button 1.
    foreach (raw[i]) raw[i] = 1'b0;
    for (int k = 0; k < 7; k++) begin
      logic b;
      b = (k < 4) ? ~k[0] : 1'b1;
      step(1'b0, {3'b000, b, 1'b0});
      check("s2_quiet", 32'({btn_level[1], btn_press[1], btn_release[1]}), 32'd0);
    end
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 5'b00000);
      check("s2_quiet", 32'({btn_level[1], btn_press[1], btn_release[1]}), 32'd0);
    end

    // Simultaneous buttons.
    for (int e = 0; e < 8; e++) begin
      step(1'b0, 5'b10101);
      if (e == 5) check("s4_press", 32'(btn_press), 32'h15);
      if (e >= 5) check("s4_level", 32'(btn_level), 32'h15);
    end
    for (int e = 0; e < 8; e++) step(1'b0, 5'b00000);

    // Reset mid-operation with button 2 held.
    for (int e = 0; e < 3; e++) step(1'b0, 5'b00100);
    step(1'b1, 5'b00100);
    check("s5_rst", 32'({btn_level, btn_press, btn_release}), 32'd0);
    for (int j = 0; j < 10; j++) begin
      step(1'b0, 5'b00100);
      check("s5_press",   32'(btn_press[2]),   32'(j == 5));
      check("s5_release", 32'(btn_release[2]), 32'd0);
    end

    // Randomized bouncing stimulus against the model.
    tgt = '0;
    for (int c = 0; c < N; c++) tmr[c] = 1;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < N; c++) begin
        tmr[c]--;
        if (tmr[c] <= 0) begin
          tgt[c] = ~tgt[c];
          tmr[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3))
                                               : int'($urandom_range(5, 40));
        end
      end
      step(($urandom_range(0, 499) == 0), tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
